// File: rtl/rom_scan_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : rom_scan_sequencer_if
// Purpose  : Valid/ready word stream carrying captured ROM words out of the
//            rom_scan_sequencer.
// Signals  : data_out      captured word
//            data_address  chip address the word was read from
//            data_valid    data_out/data_address are valid
//            data_ready    downstream accepts the current word
// Modports : master (sequencer side), slave (consumer side)
// Revision : 1.0  initial release
// ============================================================================
interface rom_scan_sequencer_if #(
   parameter int ADDRESS_WIDTH = 9,
   parameter int DATA_WIDTH    = 8
);
   logic [DATA_WIDTH-1:0]    data_out;
   logic [ADDRESS_WIDTH-1:0] data_address;
   logic                     data_valid;
   logic                     data_ready;

   modport master (
      output data_out,
      output data_address,
      output data_valid,
      input  data_ready
   );

   modport slave (
      input  data_out,
      input  data_address,
      input  data_valid,
      output data_ready
   );
endinterface
`default_nettype wire

// File: rtl/rom_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rom_scan_sequencer
// Purpose  : ROM read sequencer for the PROM dumper. Drives the chip address
//            and active-low selects, waits SETTLE_CYCLES, captures the data
//            word. Manual mode steps one address per step edge; auto mode
//            dumps the whole chip over a valid/ready stream.
// Ports    : clk, reset_n (async, active low)
//            mode_auto, start, step_up, step_down   control levels
//            chip_data_in / chip_address / chip_select_n   ROM bus
//            busy, done                              status
//            stream (rom_scan_sequencer_if.master)   captured word stream
// Option   : ROM_SCAN_CHECKSUM_EN adds checksum[15:0] (16-bit modular sum of
//            accepted auto-mode words) and checksum_valid (= done).
// Revision : 1.0  initial release
// ============================================================================
module rom_scan_sequencer #(
   parameter int ADDRESS_WIDTH = 9,
   parameter int DATA_WIDTH    = 8,
   parameter int SELECT_WIDTH  = 4,
   parameter int SETTLE_CYCLES = 4
) (
   input  wire                      clk,
   input  wire                      reset_n,
   input  wire                      mode_auto,
   input  wire                      start,
   input  wire                      step_up,
   input  wire                      step_down,
   input  wire [DATA_WIDTH-1:0]     chip_data_in,
   output logic [ADDRESS_WIDTH-1:0] chip_address,
   output logic [SELECT_WIDTH-1:0]  chip_select_n,
   output logic                     busy,
   output logic                     done,
`ifdef ROM_SCAN_CHECKSUM_EN
   output logic [15:0]              checksum,
   output logic                     checksum_valid,
`endif
   rom_scan_sequencer_if.master     stream
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SELECT  = 3'd1,
      S_SETTLE  = 3'd2,
      S_CAPTURE = 3'd3,
      S_EMIT    = 3'd4,
      S_ADVANCE = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   localparam logic [ADDRESS_WIDTH-1:0] ADDR_MAX    = '1;
   localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE    = ADDRESS_WIDTH'(1);
   localparam logic [SELECT_WIDTH-1:0]  SEL_ON      = '0;
   localparam logic [SELECT_WIDTH-1:0]  SEL_OFF     = '1;
   localparam logic [7:0]               SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

   state_t     state;
   logic       start_q;
   logic       up_q;
   logic       down_q;
   logic       auto_run;     // current run was launched by start (auto dump)
   logic [7:0] settle_cnt;

   logic start_edge;
   logic up_edge;
   logic down_edge;

   assign start_edge = start     & ~start_q;
   assign up_edge    = step_up   & ~up_q;
   assign down_edge  = step_down & ~down_q;

`ifdef ROM_SCAN_CHECKSUM_EN
   assign checksum_valid = done;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state               <= S_IDLE;
         // Previous-sample registers start high: a level that is already
         // high when reset releases must not look like a fresh edge.
         start_q             <= 1'b1;
         up_q                <= 1'b1;
         down_q              <= 1'b1;
         auto_run            <= 1'b0;
         settle_cnt          <= 8'd0;
         chip_address        <= '0;
         chip_select_n       <= SEL_OFF;
         busy                <= 1'b0;
         done                <= 1'b0;
         stream.data_out     <= '0;
         stream.data_address <= '0;
         stream.data_valid   <= 1'b0;
`ifdef ROM_SCAN_CHECKSUM_EN
         checksum            <= 16'd0;
`endif
      end else begin
         // Edge detectors run every cycle, so edges seen while busy are lost.
         start_q <= start;
         up_q    <= step_up;
         down_q  <= step_down;

         if (busy && auto_run && !mode_auto) begin
            // Auto dump abandoned: release the chip, keep the address.
            state             <= S_IDLE;
            chip_select_n     <= SEL_OFF;
            stream.data_valid <= 1'b0;
            busy              <= 1'b0;
         end else begin
            case (state)
               S_IDLE, S_DONE: begin
                  if (mode_auto && start_edge) begin
                     done          <= 1'b0;
                     auto_run      <= 1'b1;
                     chip_address  <= '0;
                     chip_select_n <= SEL_ON;
                     busy          <= 1'b1;
                     state         <= S_SELECT;
`ifdef ROM_SCAN_CHECKSUM_EN
                     checksum      <= 16'd0;
`endif
                  end else if (!mode_auto && (up_edge ^ down_edge)) begin
                     // Simultaneous up and down edges cancel out.
                     auto_run      <= 1'b0;
                     chip_address  <= up_edge ? chip_address + ADDR_ONE
                                              : chip_address - ADDR_ONE;
                     chip_select_n <= SEL_ON;
                     busy          <= 1'b1;
                     state         <= S_SELECT;
                  end
               end
               S_SELECT: begin
                  settle_cnt <= SETTLE_LOAD;
                  state      <= S_SETTLE;
               end
               S_SETTLE: begin
                  if (settle_cnt == 8'd0) begin
                     state <= S_CAPTURE;
                  end else begin
                     settle_cnt <= settle_cnt - 8'd1;
                  end
               end
               S_CAPTURE: begin
                  stream.data_out     <= chip_data_in;
                  stream.data_address <= chip_address;
                  chip_select_n       <= SEL_OFF;
                  if (auto_run) begin
                     stream.data_valid <= 1'b1;
                     state             <= S_EMIT;
                  end else begin
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end
               end
               S_EMIT: begin
                  if (stream.data_ready) begin
                     stream.data_valid <= 1'b0;
                     state             <= S_ADVANCE;
`ifdef ROM_SCAN_CHECKSUM_EN
                     checksum          <= checksum + 16'(stream.data_out);
`endif
                  end
               end
               S_ADVANCE: begin
                  if (chip_address == ADDR_MAX) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= S_DONE;
                  end else begin
                     chip_address  <= chip_address + ADDR_ONE;
                     chip_select_n <= SEL_ON;
                     state         <= S_SELECT;
                  end
               end
               default: begin
                  chip_select_n     <= SEL_OFF;
                  stream.data_valid <= 1'b0;
                  busy              <= 1'b0;
                  state             <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire
